// File: rtl/imem_arb_pkg.sv
// Shared constants, types and helpers for the instruction-memory fetch arbiter.
//   NOP_INSTR  : sll $0,$0,0, returned on faulted fetches and held in rdata after reset
//   core_idx_t : index of one requesting core
//   is_fault   : misaligned or out-of-range byte address check
package imem_arb_pkg;

  localparam int unsigned N_CORES      = 2;
  localparam int unsigned FAULT_ADDR_W = 64;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;

  typedef logic [$clog2(N_CORES)-1:0] core_idx_t;

  // A fetch faults when it is not word aligned or falls past the last ROM word.
  function automatic logic is_fault(input logic [FAULT_ADDR_W-1:0] addr,
                                    input int unsigned             depth);
    logic [FAULT_ADDR_W-1:0] limit;
    limit = FAULT_ADDR_W'(depth) << 2;
    return (addr[1:0] != 2'b00) || (addr >= limit);
  endfunction

endpackage

// File: rtl/imem_fetch_arbiter_rr.sv
// Two-way round-robin arbiter, purely combinational; the priority pointer lives in the parent.
//   req     : request per core
//   rr_ptr  : core that wins when both request
//   gnt     : one-hot grant (or zero when idle)
//   gnt_idx : index of the granted core (0 when idle)
module rr_arbiter2
  import imem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  core_idx_t  rr_ptr,
  output logic [1:0] gnt,
  output core_idx_t  gnt_idx
);

  // Lone requester always wins; contention resolved by rr_ptr.
  always_comb begin
    gnt     = 2'b00;
    gnt_idx = '0;
    case (req)
      2'b01: begin
        gnt     = 2'b01;
        gnt_idx = core_idx_t'(0);
      end
      2'b10: begin
        gnt     = 2'b10;
        gnt_idx = core_idx_t'(1);
      end
      2'b11: begin
        if (rr_ptr == core_idx_t'(1)) begin
          gnt     = 2'b10;
          gnt_idx = core_idx_t'(1);
        end else begin
          gnt     = 2'b01;
          gnt_idx = core_idx_t'(0);
        end
      end
      default: begin
        gnt     = 2'b00;
        gnt_idx = '0;
      end
    endcase
  end

endmodule

// File: rtl/imem_fetch_arbiter.sv
// Shares one combinational instruction ROM between two cores, one fetch per cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   req, addr  : per-core fetch request and byte address (slice i*ADDR_W)
//   stall      : comb, core requested but lost arbitration; it must hold its PC
//   rvalid     : reg, response for core i valid this cycle (one cycle after grant)
//   rdata, err : reg, fetched word (NOP on fault) and fault flag, held between responses
//   rom_addr   : comb, byte address of the granted fetch (0 when idle)
//   rom_rd     : comb, ROM read data for rom_addr
//   gnt_cnt    : reg, saturating grant count per core (slice i*CNT_W)
module imem_fetch_arbiter #(
  parameter int unsigned N_CORES   = 2,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ROM_DEPTH = 16,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_CORES-1:0]          req,
  input  logic [N_CORES*ADDR_W-1:0]   addr,
  output logic [N_CORES-1:0]          stall,
  output logic [N_CORES-1:0]          rvalid,
  output logic [N_CORES*DATA_W-1:0]   rdata,
  output logic [N_CORES-1:0]          err,
  output logic [ADDR_W-1:0]           rom_addr,
  input  logic [DATA_W-1:0]           rom_rd,
  output logic [N_CORES*CNT_W-1:0]    gnt_cnt
);

  import imem_arb_pkg::*;

  localparam logic [DATA_W-1:0] NOP_W   = DATA_W'(NOP_INSTR);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  logic [1:0]          gnt;
  core_idx_t           gnt_idx;
  core_idx_t           rr_ptr;
  logic                gnt_any;
  logic                fault;
  logic [ADDR_W-1:0]   sel_addr;

  rr_arbiter2 u_arb (
    .req     (req[1:0]),
    .rr_ptr  (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Route the winner's address to the ROM and classify it.
  // The ROM itself only decodes the low word-index bits; the range check here
  // guarantees those bits are meaningful whenever the data is used.
  always_comb begin
    gnt_any  = |gnt;
    sel_addr = (gnt_idx == core_idx_t'(1)) ? addr[ADDR_W +: ADDR_W] : addr[0 +: ADDR_W];
    rom_addr = gnt_any ? sel_addr : '0;
    fault    = is_fault(FAULT_ADDR_W'(sel_addr), ROM_DEPTH);
    stall    = req & ~gnt;
  end

  // Pointer, response registers and grant counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr  <= '0;
      rvalid  <= '0;
      err     <= '0;
      rdata   <= {N_CORES{NOP_W}};
      gnt_cnt <= '0;
    end else begin
      rvalid <= gnt;
      // Loser of this grant gets priority at the next contention.
      if (gnt_any) begin
        rr_ptr <= ~gnt_idx;
      end
      for (int i = 0; i < N_CORES; i++) begin
        if (gnt[i]) begin
          rdata[i*DATA_W +: DATA_W] <= fault ? NOP_W : rom_rd;
          err[i]                    <= fault;
          if (gnt_cnt[i*CNT_W +: CNT_W] != CNT_MAX) begin
            gnt_cnt[i*CNT_W +: CNT_W] <= gnt_cnt[i*CNT_W +: CNT_W] + CNT_W'(1);
          end
        end
      end
    end
  end

endmodule
